// File: rtl/bullcow_pkg.sv
// Shared types and default constants for the Bulls-and-Cows game engine.
// The optional turn limit is enabled by defining BULLCOW_TURN_LIMIT_EN.
package bullcow_pkg;

  // FSM state encoding. It is exported on the state port, so the values are fixed.
  typedef enum logic [2:0] {
    P1_SETUP = 3'b000,
    P2_SETUP = 3'b001,
    P1_GUESS = 3'b010,
    P2_GUESS = 3'b011,
    GAME_END = 3'b111
  } state_t;

  // Encoding of the winner port.
  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  // Default build configuration.
  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_DIGIT_W    = 4;
  localparam int DEF_RADIX      = 10;
  localparam int DEF_SCORE_W    = 8;
  localparam int DEF_MAX_TURNS  = 10;

  // Width needed to hold a count in the range 0..n.
  function automatic int count_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bullcow_scorer.sv
// Combinational scorer: it compares one guess with one secret and reports bulls,
// cows, and whether the guess is a legal code (every digit below RADIX, and no
// digit repeated).
module bullcow_scorer
  import bullcow_pkg::*;
#(
  parameter  int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter  int DIGIT_W    = DEF_DIGIT_W,
  parameter  int RADIX      = DEF_RADIX,
  localparam int GUESS_W    = NUM_DIGITS * DIGIT_W,
  localparam int BC_W       = count_w(NUM_DIGITS)
) (
  input  logic [GUESS_W-1:0] guess,
  input  logic [GUESS_W-1:0] secret,
  output logic [BC_W-1:0]    bulls,
  output logic [BC_W-1:0]    cows,
  output logic               valid
);

  // The pair count can only exceed NUM_DIGITS when the guess repeats a digit.
  // In that case the guess is rejected anyway, but the counter is sized so it
  // cannot wrap.
  localparam int CNT_W = count_w(NUM_DIGITS * NUM_DIGITS);
  localparam logic [DIGIT_W:0] RADIX_L = (DIGIT_W + 1)'(RADIX);

  logic [DIGIT_W-1:0] g_dig [NUM_DIGITS];
  logic [DIGIT_W-1:0] s_dig [NUM_DIGITS];
  logic [CNT_W-1:0]   bull_cnt;
  logic [CNT_W-1:0]   cow_cnt;

  // Unpack the flat digit vectors into arrays, one entry per digit.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      g_dig[i] = guess[i*DIGIT_W +: DIGIT_W];
      s_dig[i] = secret[i*DIGIT_W +: DIGIT_W];
    end
  end

  // Legality check: every digit is in range and no two positions share a digit.
  always_comb begin
    valid = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ({1'b0, g_dig[i]} >= RADIX_L) begin
        valid = 1'b0;
      end
      for (int j = i + 1; j < NUM_DIGITS; j++) begin
        if (g_dig[i] == g_dig[j]) begin
          valid = 1'b0;
        end
      end
    end
  end

  // Bulls are matches at the same position. Cows are matches between a guess
  // digit and a secret digit at any other position.
  always_comb begin
    bull_cnt = '0;
    cow_cnt  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      for (int j = 0; j < NUM_DIGITS; j++) begin
        if (g_dig[i] == s_dig[j]) begin
          if (i == j) begin
            bull_cnt = bull_cnt + CNT_W'(1);
          end else begin
            cow_cnt = cow_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  assign bulls = BC_W'(bull_cnt);
  assign cows  = BC_W'(cow_cnt);

endmodule

// File: rtl/bullcow_engine.sv
// Two-player Bulls-and-Cows game engine. The FSM runs both secret entries and
// then alternating guesses. It scores each legal guess, detects wins, and keeps
// a saturating win counter for each player.
// The optional feature is enabled by defining BULLCOW_TURN_LIMIT_EN. With it,
// the game is a draw after MAX_TURNS non-winning rounds.
module bullcow_engine
  import bullcow_pkg::*;
#(
  parameter  int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter  int DIGIT_W    = DEF_DIGIT_W,
  parameter  int RADIX      = DEF_RADIX,
  parameter  int SCORE_W    = DEF_SCORE_W,
  parameter  int MAX_TURNS  = DEF_MAX_TURNS,
  localparam int GUESS_W    = NUM_DIGITS * DIGIT_W,
  localparam int BC_W       = count_w(NUM_DIGITS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enter,
  input  logic [GUESS_W-1:0]   guess,
  output logic [2:0]           state,
  output logic                 active_player,
  output logic [BC_W-1:0]      bulls,
  output logic [BC_W-1:0]      cows,
  output logic                 result_valid,
  output logic                 input_error,
  output logic [1:0]           winner,
  output logic [2*SCORE_W-1:0] points
);

  localparam logic [BC_W-1:0] ALL_BULLS = BC_W'(NUM_DIGITS);

  // A win counter holds at all ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    if (v == {SCORE_W{1'b1}}) begin
      return v;
    end
    return v + SCORE_W'(1);
  endfunction

  state_t             state_r, state_nx;
  winner_t            winner_r, winner_nx;
  logic               enter_p1;
  logic [GUESS_W-1:0] p1_secret, p1_secret_nx;
  logic [GUESS_W-1:0] p2_secret, p2_secret_nx;
  logic [BC_W-1:0]    bulls_r, bulls_nx;
  logic [BC_W-1:0]    cows_r, cows_nx;
  logic               rv_r, rv_nx;
  logic               ie_r, ie_nx;
  logic [SCORE_W-1:0] p1_points, p1_points_nx;
  logic [SCORE_W-1:0] p2_points, p2_points_nx;
  logic               ap_r, ap_nx;

  logic               submit;
  logic [GUESS_W-1:0] sc_secret;
  logic [BC_W-1:0]    sc_bulls;
  logic [BC_W-1:0]    sc_cows;
  logic               sc_valid;

`ifdef BULLCOW_TURN_LIMIT_EN
  localparam int TURN_W = count_w(MAX_TURNS);
  localparam logic [TURN_W-1:0] LAST_TURN = TURN_W'(MAX_TURNS - 1);
  logic [TURN_W-1:0] turn_r, turn_nx;
`else
  logic [31:0] unused_max_turns;
  assign unused_max_turns = MAX_TURNS;
`endif

  // A submission is the first cycle of an enter level, so a held button counts once.
  assign submit = enter & ~enter_p1;

  // The player who is guessing is scored against the other player's secret.
  assign sc_secret = ap_r ? p1_secret : p2_secret;

  bullcow_scorer #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_W    (DIGIT_W),
    .RADIX      (RADIX)
  ) u_scorer (
    .guess  (guess),
    .secret (sc_secret),
    .bulls  (sc_bulls),
    .cows   (sc_cows),
    .valid  (sc_valid)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= P1_SETUP;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next state and next values of all game registers. Every response is
  // decided at the edge that samples the submission.
  always_comb begin
    state_nx     = state_r;
    winner_nx    = winner_r;
    p1_secret_nx = p1_secret;
    p2_secret_nx = p2_secret;
    bulls_nx     = bulls_r;
    cows_nx      = cows_r;
    rv_nx        = 1'b0;
    ie_nx        = 1'b0;
    p1_points_nx = p1_points;
    p2_points_nx = p2_points;
    ap_nx        = ap_r;
`ifdef BULLCOW_TURN_LIMIT_EN
    turn_nx      = turn_r;
`endif

    case (state_r)
      P1_SETUP: begin
        if (submit) begin
          if (sc_valid) begin
            p1_secret_nx = guess;
            state_nx     = P2_SETUP;
          end else begin
            ie_nx = 1'b1;
          end
        end
      end

      P2_SETUP: begin
        if (submit) begin
          if (sc_valid) begin
            p2_secret_nx = guess;
            state_nx     = P1_GUESS;
          end else begin
            ie_nx = 1'b1;
          end
        end
      end

      P1_GUESS: begin
        if (submit) begin
          if (!sc_valid) begin
            ie_nx = 1'b1;
          end else begin
            bulls_nx = sc_bulls;
            cows_nx  = sc_cows;
            rv_nx    = 1'b1;
            if (sc_bulls == ALL_BULLS) begin
              p1_points_nx = sat_inc(p1_points);
              winner_nx    = WIN_P1;
              state_nx     = GAME_END;
            end else begin
              state_nx = P2_GUESS;
            end
          end
        end
      end

      P2_GUESS: begin
        if (submit) begin
          if (!sc_valid) begin
            ie_nx = 1'b1;
          end else begin
            bulls_nx = sc_bulls;
            cows_nx  = sc_cows;
            rv_nx    = 1'b1;
`ifdef BULLCOW_TURN_LIMIT_EN
            turn_nx  = turn_r + TURN_W'(1);
`endif
            if (sc_bulls == ALL_BULLS) begin
              p2_points_nx = sat_inc(p2_points);
              winner_nx    = WIN_P2;
              state_nx     = GAME_END;
`ifdef BULLCOW_TURN_LIMIT_EN
            end else if (turn_r == LAST_TURN) begin
              winner_nx = WIN_DRAW;
              state_nx  = GAME_END;
`endif
            end else begin
              state_nx = P1_GUESS;
            end
          end
        end
      end

      GAME_END: begin
        // Any press, legal or not, starts a new game. Points are kept.
        if (submit) begin
          p1_secret_nx = '0;
          p2_secret_nx = '0;
          bulls_nx     = '0;
          cows_nx      = '0;
          winner_nx    = WIN_NONE;
          state_nx     = P1_SETUP;
`ifdef BULLCOW_TURN_LIMIT_EN
          turn_nx      = '0;
`endif
        end
      end

      default: begin
        state_nx = P1_SETUP;
      end
    endcase

    // The active player follows the state being entered and holds in GAME_END.
    case (state_nx)
      P1_SETUP, P1_GUESS: ap_nx = 1'b0;
      P2_SETUP, P2_GUESS: ap_nx = 1'b1;
      default:            ap_nx = ap_r;
    endcase
  end

  // Game datapath and status registers. Reset returns everything, including
  // points, to its initial value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enter_p1  <= 1'b0;
      winner_r  <= WIN_NONE;
      p1_secret <= '0;
      p2_secret <= '0;
      bulls_r   <= '0;
      cows_r    <= '0;
      rv_r      <= 1'b0;
      ie_r      <= 1'b0;
      p1_points <= '0;
      p2_points <= '0;
      ap_r      <= 1'b0;
    end else begin
      enter_p1  <= enter;
      winner_r  <= winner_nx;
      p1_secret <= p1_secret_nx;
      p2_secret <= p2_secret_nx;
      bulls_r   <= bulls_nx;
      cows_r    <= cows_nx;
      rv_r      <= rv_nx;
      ie_r      <= ie_nx;
      p1_points <= p1_points_nx;
      p2_points <= p2_points_nx;
      ap_r      <= ap_nx;
    end
  end

`ifdef BULLCOW_TURN_LIMIT_EN
  // Per-game turn counter. It advances on each scored P2 guess.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      turn_r <= '0;
    end else begin
      turn_r <= turn_nx;
    end
  end
`endif

  assign state         = state_r;
  assign active_player = ap_r;
  assign bulls         = bulls_r;
  assign cows          = cows_r;
  assign result_valid  = rv_r;
  assign input_error   = ie_r;
  assign winner        = winner_r;
  assign points        = {p2_points, p1_points};

endmodule
